// File: rtl/lector_colas_rr.sv
// Queue reader: turns arbiter grants into one-hot pops and buffers the returned words (grant-to-valid 2 cycles).
// Backpressure refuses grants via a credit check; optional per-queue served counters under LECTOR_COLAS_CONTADORES_EN.
module lector_colas_rr #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int OUT_DEPTH      = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0]   selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] buf_data,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                data_valid,
  input  logic                                out_ready,
`ifdef LECTOR_COLAS_CONTADORES_EN
  output logic [QUEUE_QUANTITY*16-1:0]        served_count,
`endif
  output logic                                grant_drop
);

  localparam int SEL_W = $clog2(QUEUE_QUANTITY);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int OCC_W = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 inflight_q;
  logic [SEL_W-1:0]     sel_q;
  logic [DATA_BITS-1:0] data_out_q, data_out_d, cap_word;
  logic                 grant_drop_q;
  logic                 sel_ok, accept, cap, deq;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FULL means occ + inflight has used every buffer slot, so it doubles as the credit check
  assign sel_ok   = {1'b0, selector} < (SEL_W + 1)'(QUEUE_QUANTITY);
  assign accept   = !rst & enb & selector_enb & sel_ok & !buf_empty[selector] & (state_q != FULL);
  assign cap      = inflight_q;
  assign cap_word = buf_data[sel_q*DATA_BITS +: DATA_BITS];
  assign deq      = (occ_q != '0) & out_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      pop[i] = accept && (selector == SEL_W'(i));
    end
  end

  always_comb begin
    head_d     = deq ? inc_ptr(head_q) : head_q;
    tail_d     = cap ? inc_ptr(tail_q) : tail_q;
    occ_d      = occ_q + OCC_W'(cap) - OCC_W'(deq);
    data_out_d = data_out_q;
    // The new head may be the word landing this very edge
    if (occ_d != '0) begin
      data_out_d = (cap && (tail_q == head_d)) ? cap_word : mem_q[head_d];
    end
    if ((32'(occ_d) + 32'(accept)) == OUT_DEPTH) begin
      state_d = FULL;
    end else if ((occ_d == '0) && !accept) begin
      state_d = IDLE;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      inflight_q   <= 1'b0;
      sel_q        <= '0;
      data_out_q   <= '0;
      grant_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      inflight_q   <= accept;
      data_out_q   <= data_out_d;
      grant_drop_q <= selector_enb & !accept;
      if (accept) sel_q <= selector;
      if (cap) mem_q[tail_q] <= cap_word;
    end
  end

`ifdef LECTOR_COLAS_CONTADORES_EN
  logic [QUEUE_QUANTITY*16-1:0] served_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      served_count_q <= '0;
    end else begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        if (pop[i]) served_count_q[i*16 +: 16] <= served_count_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign served_count = served_count_q;
`endif

  assign data_out   = data_out_q;
  assign data_valid = (occ_q != '0);
  assign grant_drop = grant_drop_q;

endmodule

// File: tb/tb_lector_colas_rr.sv
// Bench for lector_colas_rr: per-cycle vector table for pop/grant_drop/data_valid plus a word scoreboard fed by a queue-bank model.
module tb_lector_colas_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enb = 1'b1;
  logic [1:0]  selector = '0;
  logic        selector_enb = 1'b0;
  logic [3:0]  buf_empty = '0;
  logic [31:0] buf_data = '0;
  logic [3:0]  pop;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        out_ready = 1'b1;
  logic        grant_drop;
`ifdef LECTOR_COLAS_CONTADORES_EN
  logic [63:0] served_count;
  logic [63:0] sc0;
  logic [15:0] sc_delta;
`endif

  lector_colas_rr #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .OUT_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
    .buf_empty(buf_empty), .buf_data(buf_data), .pop(pop), .data_out(data_out),
    .data_valid(data_valid), .out_ready(out_ready),
`ifdef LECTOR_COLAS_CONTADORES_EN
    .served_count(served_count),
`endif
    .grant_drop(grant_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       enb;
    logic [1:0] sel;
    logic       sel_enb;
    logic [3:0] empty;
    logic       ready;
    logic [3:0] exp_pop;
    logic       exp_drop;
    logic       exp_valid;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          pops_seen = 0;
  logic [7:0]  sb [$];
  logic [3:0]  bank_cnt [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  vec_t        vecs [$];

  function automatic logic [7:0] word(input int q, input logic [3:0] n);
    return 8'hA3 + 8'(q) + {n, 4'h0};
  endfunction

  // Queue bank model: synchronous read, word valid the cycle after its pop
  always @(posedge clk) begin
    for (int q = 0; q < 4; q++) begin
      if (pop[q]) begin
        buf_data[q*8 +: 8] <= word(q, bank_cnt[q]);
        bank_cnt[q]        <= bank_cnt[q] + 4'd1;
      end
    end
  end

  function automatic vec_t v(input int e, input int s, input int se, input int em,
                             input int r, input int p, input int d, input int vl);
    vec_t t;
    t.enb = 1'(e); t.sel = 2'(s); t.sel_enb = 1'(se); t.empty = 4'(em); t.ready = 1'(r);
    t.exp_pop = 4'(p); t.exp_drop = 1'(d); t.exp_valid = 1'(vl);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string nm);
    logic [7:0] e;
    enb = t.enb; selector = t.sel; selector_enb = t.sel_enb;
    buf_empty = t.empty; out_ready = t.ready;
    @(negedge clk);
    chk({nm, " pop"}, 32'(pop), 32'(t.exp_pop));
    chk({nm, " grant_drop"}, 32'(grant_drop), 32'(t.exp_drop));
    chk({nm, " data_valid"}, 32'(data_valid), 32'(t.exp_valid));
    pops_seen += $countones(pop);
    if (rst) begin
      sb.delete();
    end else begin
      if (data_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk({nm, " unexpected word"}, 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk({nm, " data_out"}, 32'(data_out), 32'(e));
        end
      end
      for (int q = 0; q < 4; q++) begin
        if (pop[q]) sb.push_back(word(q, bank_cnt[q]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single grant, empty queue, backpressure, enb=0
    vecs.push_back(v(1,2,1,0,1,4,0,0)); vecs.push_back(v(1,0,0,0,1,0,0,0));
    vecs.push_back(v(1,0,0,0,1,0,0,1)); vecs.push_back(v(1,0,0,0,1,0,0,0));
    vecs.push_back(v(1,1,1,2,1,0,0,0)); vecs.push_back(v(1,0,0,0,1,0,1,0));
    vecs.push_back(v(1,0,0,0,1,0,0,0));
    vecs.push_back(v(1,0,1,0,0,1,0,0)); vecs.push_back(v(1,0,1,0,0,1,0,0));
    vecs.push_back(v(1,0,1,0,0,1,0,1)); vecs.push_back(v(1,0,1,0,0,0,0,1));
    vecs.push_back(v(1,0,1,0,0,0,1,1)); vecs.push_back(v(1,0,1,0,0,0,1,1));
    vecs.push_back(v(1,0,1,0,1,0,1,1)); vecs.push_back(v(1,0,1,0,1,1,1,1));
    vecs.push_back(v(1,0,1,0,1,1,0,1)); vecs.push_back(v(1,0,1,0,1,1,0,1));
    vecs.push_back(v(1,0,0,0,1,0,0,1)); vecs.push_back(v(1,0,0,0,1,0,0,1));
    vecs.push_back(v(1,0,0,0,1,0,0,0));
    vecs.push_back(v(0,3,1,0,1,0,0,0)); vecs.push_back(v(1,0,0,0,1,0,1,0));
    vecs.push_back(v(1,0,0,0,1,0,0,0));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset pop", 32'(pop), 32'h0);
    chk("reset data_valid", 32'(data_valid), 32'h0);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset grant_drop", 32'(grant_drop), 32'h0);
`ifdef LECTOR_COLAS_CONTADORES_EN
    chk("reset served_count", served_count[31:0] | served_count[63:32], 32'h0);
`endif
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // streaming: grants cycling 0..3, one word per cycle, no drops
`ifdef LECTOR_COLAS_CONTADORES_EN
    sc0 = served_count;
`endif
    for (int i = 0; i < 8; i++) begin
      step(v(1, i % 4, 1, 0, 1, 1 << (i % 4), 0, (i >= 2) ? 1 : 0), $sformatf("stream%0d", i));
    end
    step(v(1,0,0,0,1,0,0,1), "stream_tail0");
    step(v(1,0,0,0,1,0,0,1), "stream_tail1");
    step(v(1,0,0,0,1,0,0,0), "stream_tail2");
`ifdef LECTOR_COLAS_CONTADORES_EN
    for (int q = 0; q < 4; q++) begin
      sc_delta = served_count[q*16 +: 16] - sc0[q*16 +: 16];
      chk($sformatf("served_count q%0d", q), 32'(sc_delta), 32'd2);
    end
`endif

    // reset while a word is in flight: it must never appear
    step(v(1,3,1,0,1,8,0,0), "rst_grant");
    rst = 1'b1;
    step(v(1,0,0,0,1,0,0,0), "rst_cycle");
    rst = 1'b0;
    step(v(1,0,0,0,1,0,0,0), "post_rst0");
    chk("post_rst data_out", 32'(data_out), 32'h0);
    step(v(1,0,0,0,1,0,0,0), "post_rst1");
    step(v(1,0,0,0,1,0,0,0), "post_rst2");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    chk("total pops", 32'(pops_seen), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lector_colas_rr.md
Name: lector_colas_rr

Overview:
- Consumer end of the weighted round-robin arbiter: turns `selector`/`selector_enb` grants into a one-cycle `pop` on the selected queue FIFO.
- Captures the popped word from the queue bank's read bus and buffers it in a small output FIFO with valid/ready handshake.
- Sits between the queue bank plus `roundRobinPesado` and the downstream output port; absorbs backpressure by refusing grants.

Parameters:
- QUEUE_QUANTITY, 4, number of queues; selector width is $clog2(QUEUE_QUANTITY).
- DATA_BITS, 8, word width per queue.
- OUT_DEPTH, 3, output buffer entries; legal range 2..8; 3 gives one word per cycle sustained.

Ports:
- clk  input  1  single clock; everything samples on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enb  input  1  global enable; when 0, no grant is accepted and state holds except output dequeue.
- selector  input  $clog2(QUEUE_QUANTITY)  queue chosen by the arbiter.
- selector_enb  input  1  grant valid.
- buf_empty  input  QUEUE_QUANTITY  per-queue empty flags.
- buf_data  input  QUEUE_QUANTITY*DATA_BITS  queue read data; queue i occupies [i*DATA_BITS +: DATA_BITS]; valid the cycle after its pop (synchronous read).
- pop  output  QUEUE_QUANTITY  one-hot read strobe, combinational from accept.
- data_out  output  DATA_BITS  head of output buffer.
- data_valid  output  1  output buffer non-empty.
- out_ready  input  1  downstream accepts data_out this cycle.
- grant_drop  output  1  registered pulse: a grant was refused last cycle.

Behaviour:
- Reset (rst=1 at edge): buffer empty, inflight=0, data_valid=0, data_out=0, grant_drop=0, pop=0 the cycle after. rst has priority over every other input.
- occ = output buffer occupancy; inflight = 1 if a pop was issued the previous cycle, else 0.
- accept = enb & selector_enb & !buf_empty[selector] & (occ+inflight < OUT_DEPTH). Use current-cycle occ, not counting a same-cycle dequeue.
- Accept cycle N:
  - pop[selector]=1 in cycle N; all other pop bits 0.
  - selector is registered as sel_q and inflight is set.
- Cycle N+1: at the closing edge, buf_data slice sel_q is written into the buffer tail and inflight clears unless a new accept occurred.
- data_valid rises in N+2. Grant-to-valid latency is 2 cycles.
- Dequeue: data_valid & out_ready at an edge removes the head. data_out shows the next entry, or holds its last value (data_valid=0) when the buffer empties.
- Simultaneous capture and dequeue: both take effect and occ is unchanged. This is legal even at occ=OUT_DEPTH because the credit check prevents overflow.
- grant_drop=1 in cycle N+1 whenever selector_enb=1 in N but accept=0, for any reason (empty queue, no credit, enb=0).
- Buffer: circular, head/tail pointers wrap modulo OUT_DEPTH, occ counter of width $clog2(OUT_DEPTH+1).
- Internal states:
  - IDLE: occ=0, inflight=0.
  - RUN: otherwise, credit available.
  - FULL: occ+inflight=OUT_DEPTH.
  - Transitions follow the occ/inflight updates. State is observable only through data_valid and grant_drop/accept.
- Reset mid-operation: an in-flight word is discarded and its queue pop is not replayed. This is a known data loss, accepted at reset.
- Out-of-range selector (selector >= QUEUE_QUANTITY): treated as refused, with grant_drop.

Optional Feature:
- Macro LECTOR_COLAS_CONTADORES_EN.
- When defined: adds output `served_count` of width QUEUE_QUANTITY*16, one 16-bit counter per queue.
  - A queue's counter increments on each accepted grant to that queue and wraps at 16'hFFFF to 0.
  - All counters clear on rst.
- When undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then single grant: rst 2 cycles; selector=2, selector_enb=1 for 1 cycle, buf_empty=0, buf_data slice2=8'hA5, out_ready=1 -> pop=4'b0100 that cycle; data_valid=1 and data_out=8'hA5 exactly 2 cycles later for 1 cycle; grant_drop stays 0.
- Empty queue: selector=1, buf_empty=4'b0010, selector_enb=1 -> pop=0; grant_drop=1 next cycle; data_valid stays 0.
- Backpressure: out_ready=0, grants every cycle to queue 0 with non-empty data -> exactly 3 pops; the 4th grant onward gives grant_drop=1; then out_ready=1 -> words drain in order, pops resume, throughput 1/cycle.
- Streaming: out_ready=1, grants cycling 0,1,2,3 for 8 cycles -> 8 pops, 8 words out in grant order, no drops.
- Reset mid-flight: grant accepted, rst asserted next cycle -> data_valid=0 and occ=0 after reset; no word appears.
- Run with LECTOR_COLAS_CONTADORES_EN defined: after the streaming test, served_count = 2 for each queue.
